i2c_slave_rx: RTL and testbench

Oversampling I2C target that consumes the SCL/SDA bus driven by the team's I2C master. Detects START/STOP, matches a 7-bit address, ACKs, and delivers each written byte to local logic as a one-cycle strobe. Optionally serves read transfers from a local byte source. Sits on the bus side opposite the master, clocked by its own system clock.

---
 rtl/i2c_slave_rx.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: oversampling I2C target with 7-bit address match, write-byte strobe
// and optional read service from tx_data (enabled by defining I2C_SLAVE_READ_EN).
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       rw,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WDATA    = 3'd3;
  localparam logic [2:0] WACK     = 3'd4;
`ifdef I2C_SLAVE_READ_EN
  localparam logic [2:0] RDATA    = 3'd5;
  localparam logic [2:0] RACK     = 3'd6;
`endif
  localparam logic [2:0] IGNORE   = 3'd7;

  logic       scl_m, scl_s, scl_d;
  logic       sda_m, sda_s, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] state;
  logic [2:0] cnt;
  logic [7:0] shift;
  logic       drive;
  logic       addr_hit;
`ifdef I2C_SLAVE_READ_EN
  logic       ack_seen;
`else
  logic       unused_tx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {scl_m, scl_s, scl_d} <= '1;
      {sda_m, sda_s, sda_d} <= '1;
    end else begin
      scl_m <= scl_in;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda_in;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  // shift[6:0] holds address bits 7..1 while sda_s carries the R/W bit
`ifdef I2C_SLAVE_READ_EN
  assign addr_hit = (shift[6:0] == SLAVE_ADDR);
  assign tx_load  = scl_fall & ~start_det & ~stop_det &
                    (((state == ADDR_ACK) & drive & rw) | ((state == RACK) & ack_seen));
`else
  assign addr_hit  = (shift[6:0] == SLAVE_ADDR) & ~sda_s;
  assign tx_load   = 1'b0;
  assign unused_tx = ^tx_data;
`endif

  // ACK phases use drive itself as the half-bit marker: first falling edge
  // asserts the pull-down, the second releases it and leaves the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      drive    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      ack_seen <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (stop_det) begin
        state <= IDLE;
        drive <= 1'b0;
        busy  <= 1'b0;
      end else if (start_det) begin
        state <= ADDR;
        cnt   <= 3'd7;
        drive <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_s};
              if (cnt == 3'd0) begin
                if (addr_hit) begin
                  state <= ADDR_ACK;
                  rw    <= sda_s;
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end else begin
                cnt <= cnt - 3'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!drive) begin
                drive <= 1'b1;
              end else begin
                drive <= 1'b0;
                cnt   <= 3'd7;
                state <= WDATA;
`ifdef I2C_SLAVE_READ_EN
                if (rw) begin
                  state <= RDATA;
                  shift <= tx_data;
                  drive <= ~tx_data[7];
                end
`endif
              end
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_s};
              if (cnt == 3'd0) begin
                rx_data  <= {shift[6:0], sda_s};
                rx_valid <= 1'b1;
                state    <= WACK;
              end else begin
                cnt <= cnt - 3'd1;
              end
            end
          end
          WACK: begin
            if (scl_fall) begin
              if (!drive) begin
                drive <= 1'b1;
              end else begin
                drive <= 1'b0;
                cnt   <= 3'd7;
                state <= WDATA;
              end
            end
          end
`ifdef I2C_SLAVE_READ_EN
          RDATA: begin
            if (scl_fall) begin
              if (cnt == 3'd0) begin
                drive    <= 1'b0;
                ack_seen <= 1'b0;
                state    <= RACK;
              end else begin
                shift <= {shift[6:0], 1'b0};
                drive <= ~shift[6];
                cnt   <= cnt - 3'd1;
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (!sda_s) ack_seen <= 1'b1;
              else        state    <= IGNORE;
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              shift    <= tx_data;
              drive    <= ~tx_data[7];
              cnt      <= 3'd7;
              state    <= RDATA;
            end
          end
`endif
          default: begin
            drive <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output stage keeps SDA changes well inside the SCL low phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sda_oe <= 1'b0;
    else        sda_oe <= drive;
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: bit-banged I2C master with a frame-level model of the expected
// target behaviour (ACKs, delivered bytes, read data, strobes and latencies).
module tb_i2c_slave_rx;

  localparam int Q = 40;
`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_load, rw, busy;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl_in  (scl_m),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .rw      (rw),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] rx_q[$];
  int         rx_lat_q[$];
  logic [7:0] txc_q[$];
  logic [7:0] wbytes[$];
  int         tx_loads = 0;
  int         oe_lat_bad = 0;
  int         both_bad = 0;
  bit         oe_seen = 0;
  logic       oe_prev = 1'b0;
  time        last_rise = 0;
  time        last_fall = 0;

  always @(posedge scl_m) last_rise = $time;
  always @(negedge scl_m) last_fall = $time;

  // Raw SCL edges land mid-low-clk; 3 clk to rx_valid is seen at the negedge 30 later,
  // 4 clk to sda_oe at the negedge 40 later.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_lat_q.push_back(int'($time - last_rise));
    end
    if (tx_load) begin
      tx_loads++;
      txc_q.push_back(tx_data);
    end
    if (rx_valid && tx_load) both_bad++;
    if (sda_oe) oe_seen = 1;
    if (sda_oe && !oe_prev && reset && ($time - last_fall != 40)) oe_lat_bad++;
    oe_prev = sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wbit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic start_cond();
    if (scl_m) begin
      sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    end else begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    end
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    acked = ~a;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      rbit(x);
      b[i] = x;
    end
    wbit(~ack);
  endtask

  // Full write frame of wbytes to address byte ab, compared against the model.
  task automatic do_write(input logic [7:0] ab, input string tag);
    logic       a;
    bit         exp_ack;
    logic [7:0] exp_rx[$];
    exp_ack = (ab[7:1] == 7'h50) && (!ab[0] || READ_EN);
    rx_q.delete();
    rx_lat_q.delete();
    oe_seen = 0;
    start_cond();
    send_byte(ab, a);
    check({tag, " addr ack"}, a, exp_ack);
    check({tag, " busy"}, busy, exp_ack);
    if (exp_ack) check({tag, " rw"}, rw, ab[0]);
    foreach (wbytes[i]) begin
      send_byte(wbytes[i], a);
      check({tag, " data ack"}, a, exp_ack);
      if (exp_ack) exp_rx.push_back(wbytes[i]);
    end
    stop_cond();
    check({tag, " rx count"}, rx_q.size(), exp_rx.size());
    foreach (exp_rx[i]) begin
      if (i < rx_q.size()) begin
        check({tag, " rx byte"}, rx_q[i], exp_rx[i]);
        check({tag, " rx latency"}, rx_lat_q[i], 30);
      end
    end
    if (exp_rx.size() > 0) check({tag, " rx_data held"}, rx_data, exp_rx[exp_rx.size()-1]);
    if (!exp_ack) check({tag, " oe quiet"}, oe_seen, 0);
    check({tag, " busy after stop"}, busy, 0);
  endtask

  initial begin
    logic       a;
    logic [7:0] b1, b2, ab;
    int         n, loads0;

    #30;
    check("reset sda_oe", sda_oe, 0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 0);
    check("reset tx_load", tx_load, 0);
    check("reset rw", rw, 0);
    check("reset busy", busy, 0);
    reset = 1'b1;
    #40;

    wbytes = '{8'h3C, 8'hC3};
    do_write(8'hA0, "wr50");

    wbytes = '{8'hFF};
    do_write(8'hA2, "wr51");

    // Read frame: ACKed and served when reads are enabled, NACKed otherwise.
    tx_data  = 8'h96;
    tx_loads = 0;
    txc_q.delete();
    oe_seen = 0;
    start_cond();
    send_byte(8'hA1, a);
    check("rd addr ack", a, READ_EN);
    check("rd busy", busy, READ_EN);
    check("rd rw", rw, READ_EN);
    if (READ_EN) begin
      for (int i = 7; i >= 0; i--) begin
        logic x;
        rbit(x);
        b1[i] = x;
      end
      tx_data = 8'h5A;
      wbit(1'b0);
      recv_byte(1'b0, b2);
      oe_seen = 0;
      wbit(1'b1);
      wbit(1'b0);
      check("rd byte1", b1, 8'h96);
      check("rd byte2", b2, 8'h5A);
      check("rd ignore quiet", oe_seen, 0);
      check("rd busy before stop", busy, 1);
      check("rd tx_load count", tx_loads, 2);
      if (txc_q.size() == 2) begin
        check("rd load1", txc_q[0], 8'h96);
        check("rd load2", txc_q[1], 8'h5A);
      end
    end else begin
      check("rd nack quiet", oe_seen, 0);
      check("rd tx_load count", tx_loads, 0);
    end
    stop_cond();
    check("rd busy after stop", busy, 0);

    // Partial byte cut by repeated START.
    rx_q.delete();
    start_cond();
    send_byte(8'hA0, a);
    check("rs addr1 ack", a, 1);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    start_cond();
    send_byte(8'hA0, a);
    check("rs addr2 ack", a, 1);
    send_byte(8'h11, a);
    check("rs data ack", a, 1);
    stop_cond();
    check("rs rx count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rs rx byte", rx_q[0], 8'h11);
    check("rs rx_data", rx_data, 8'h11);

    // STOP inside the address byte.
    rx_q.delete();
    oe_seen = 0;
    loads0 = tx_loads;
    start_cond();
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    stop_cond();
    check("sp oe quiet", oe_seen, 0);
    check("sp rx count", rx_q.size(), 0);
    check("sp tx_load", tx_loads, loads0);
    check("sp busy", busy, 0);

    // Reset while the data ACK is being driven.
    rx_q.delete();
    start_cond();
    send_byte(8'hA0, a);
    check("rst addr ack", a, 1);
    for (int i = 7; i >= 0; i--) wbit(i[0]);
    n = 0;
    while (!sda_oe && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst oe before", sda_oe, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #2;
    check("rst oe released", sda_oe, 0);
    check("rst busy", busy, 0);
    check("rst rx_valid", rx_valid, 0);
    check("rst rx count", rx_q.size(), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stop_cond();
    wbytes = '{8'($urandom)};
    do_write(8'hA0, "post rst");

    // Randomized write frames.
    for (int f = 0; f < 5; f++) begin
      ab = {($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom), 1'b0};
      wbytes.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) wbytes.push_back(8'($urandom));
      do_write(ab, "rand");
    end

    check("oe latency", oe_lat_bad, 0);
    check("strobe overlap", both_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
